// File: rtl/spi_sensor_seq.sv
// UART-triggered BMP280-style SPI sequencer: ID check, config writes, status poll, burst read, UART stream.
// Build option SEQ_FRAME_EN wraps the UART stream as A5 / payload / XOR-of-payload.
module spi_sensor_seq #(
    parameter int                   DATA_BITS  = 8,
    parameter logic [DATA_BITS-1:0] TRIG_CHAR  = 8'h6D,
    parameter logic [DATA_BITS-1:0] ID_ADDR    = 8'hD0,
    parameter logic [DATA_BITS-1:0] EXP_ID     = 8'h58,
    parameter logic [DATA_BITS-1:0] CTRL_ADDR  = 8'hF4,
    parameter logic [DATA_BITS-1:0] CTRL_VAL   = 8'h27,
    parameter logic [DATA_BITS-1:0] CFG_ADDR   = 8'hF5,
    parameter logic [DATA_BITS-1:0] CFG_VAL    = 8'h00,
    parameter logic [DATA_BITS-1:0] STAT_ADDR  = 8'hF3,
    parameter int                   BUSY_BIT   = 3,
    parameter logic [DATA_BITS-1:0] BURST_ADDR = 8'hF7,
    parameter int                   BURST_LEN  = 6,
    parameter int                   POLL_LIMIT = 255
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 uart_valid_in,
    input  logic [DATA_BITS-1:0] uart_data_in,
    input  logic                 uart_ready_in,
    output logic                 uart_en,
    output logic [DATA_BITS-1:0] uart_data_out,
    input  logic                 spi_ready_in,
    input  logic                 spi_valid_in,
    input  logic [DATA_BITS-1:0] spi_data_in,
    output logic                 spi_en,
    output logic [DATA_BITS-1:0] spi_data_out,
    output logic [5:0]           spi_data_words,
    output logic                 tied_SS,
    output logic                 busy,
    output logic                 error
);

    localparam int NBUF = BURST_LEN + 1;
    localparam int BW   = $clog2(NBUF);
    localparam int PW   = $clog2(POLL_LIMIT + 1);
    localparam int TXW  = 7;
    localparam logic [DATA_BITS-1:0] RD_FLAG   = {1'b1, {(DATA_BITS-1){1'b0}}};
    localparam logic [DATA_BITS-1:0] CODE_ID   = DATA_BITS'(8'hEE);
    localparam logic [DATA_BITS-1:0] CODE_POLL = DATA_BITS'(8'hEF);
`ifdef SEQ_FRAME_EN
    localparam logic [DATA_BITS-1:0] FRAME_SOF   = DATA_BITS'(8'hA5);
    localparam logic [TXW-1:0]       TX_LEN_DATA = TXW'(NBUF + 2);
    localparam logic [TXW-1:0]       TX_LEN_ERR  = TXW'(3);
`else
    localparam logic [TXW-1:0]       TX_LEN_DATA = TXW'(NBUF);
    localparam logic [TXW-1:0]       TX_LEN_ERR  = TXW'(1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ID, S_WCTRL, S_WCFG, S_POLL, S_BURST, S_TX, S_ERR
    } state_t;

    typedef enum logic [1:0] {PH_SEND, PH_WLO, PH_WHI} tx_ph_t;

    state_t               state_q, state_d;
    tx_ph_t               tx_ph_q;
    logic                 spi_en_q, tied_q, err_q, uart_en_q;
    logic [5:0]           words_q, wcnt_q;
    logic [PW-1:0]        poll_q;
    logic [TXW-1:0]       tx_idx_q;
    logic [DATA_BITS-1:0] code_q, uart_dat_q;
    logic [DATA_BITS-1:0] buf_q [NBUF];

    logic                 trig, spi_st, issue, word_v, last, tx_st, tx_done;
    logic [5:0]           txn_words;
    logic [TXW-1:0]       tx_len;
    logic [DATA_BITS-1:0] spi_word, tx_byte;

    assign trig    = uart_valid_in && (uart_data_in == TRIG_CHAR);
    assign spi_st  = state_q inside {S_ID, S_WCTRL, S_WCFG, S_POLL, S_BURST};
    assign issue   = spi_st && !tied_q && spi_ready_in;
    // Words seen while no transaction is open are not ours to count.
    assign word_v  = spi_valid_in && tied_q;
    assign last    = word_v && (wcnt_q == words_q - 6'd1);
    assign tx_st   = (state_q == S_TX) || (state_q == S_ERR);
    assign tx_len  = (state_q == S_ERR) ? TX_LEN_ERR : TX_LEN_DATA;
    assign tx_done = tx_st && (tx_ph_q == PH_WHI) && uart_ready_in && (tx_idx_q == tx_len);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (trig) state_d = S_ID;
            S_ID:    if (last) state_d = (spi_data_in == EXP_ID) ? S_WCTRL : S_ERR;
            S_WCTRL: if (last) state_d = S_WCFG;
            S_WCFG:  if (last) state_d = S_POLL;
            S_POLL: begin
                if (last) begin
                    if (!spi_data_in[BUSY_BIT])                      state_d = S_BURST;
                    else if (poll_q + PW'(1) == PW'(POLL_LIMIT))     state_d = S_ERR;
                end
            end
            S_BURST: if (last) state_d = S_TX;
            S_TX, S_ERR: if (tx_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        spi_word  = '0;
        txn_words = 6'd2;
        case (state_q)
            S_ID:    spi_word = (wcnt_q == 6'd0) ? (ID_ADDR | RD_FLAG) : '0;
            S_WCTRL: spi_word = (wcnt_q == 6'd0) ? (CTRL_ADDR & ~RD_FLAG) : CTRL_VAL;
            S_WCFG:  spi_word = (wcnt_q == 6'd0) ? (CFG_ADDR & ~RD_FLAG) : CFG_VAL;
            S_POLL:  spi_word = (wcnt_q == 6'd0) ? (STAT_ADDR | RD_FLAG) : '0;
            S_BURST: begin
                spi_word  = (wcnt_q == 6'd0) ? (BURST_ADDR | RD_FLAG) : '0;
                txn_words = 6'(NBUF);
            end
            default: ;
        endcase
    end

`ifdef SEQ_FRAME_EN
    logic [DATA_BITS-1:0] xsum;
    always_comb begin
        xsum = '0;
        for (int i = 0; i < NBUF; i++) xsum = xsum ^ buf_q[i];
        tx_byte = '0;
        if (state_q == S_ERR)                 tx_byte = (tx_idx_q == '0) ? FRAME_SOF : code_q;
        else if (tx_idx_q == '0)              tx_byte = FRAME_SOF;
        else if (tx_idx_q == TXW'(NBUF + 1))  tx_byte = xsum;
        else                                  tx_byte = buf_q[BW'(tx_idx_q - TXW'(1))];
    end
`else
    always_comb begin
        tx_byte = '0;
        if (state_q == S_ERR) tx_byte = code_q;
        else                  tx_byte = buf_q[BW'(tx_idx_q)];
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            spi_en_q   <= 1'b0;
            tied_q     <= 1'b0;
            err_q      <= 1'b0;
            uart_en_q  <= 1'b0;
            words_q    <= '0;
            wcnt_q     <= '0;
            poll_q     <= '0;
            tx_idx_q   <= '0;
            tx_ph_q    <= PH_SEND;
            code_q     <= '0;
            uart_dat_q <= '0;
            for (int i = 0; i < NBUF; i++) buf_q[i] <= '0;
        end else begin
            spi_en_q  <= 1'b0;
            uart_en_q <= 1'b0;
            if (state_q == S_IDLE && trig) begin
                err_q    <= 1'b0;
                wcnt_q   <= '0;
                poll_q   <= '0;
                tx_idx_q <= '0;
                tx_ph_q  <= PH_SEND;
            end
            if (issue) begin
                spi_en_q <= 1'b1;
                tied_q   <= 1'b1;
                words_q  <= txn_words;
                wcnt_q   <= '0;
            end
            if (word_v) begin
                wcnt_q <= last ? 6'd0 : wcnt_q + 6'd1;
                if (state_q == S_ID && wcnt_q == 6'd1)     buf_q[0] <= spi_data_in;
                if (state_q == S_BURST && wcnt_q != 6'd0)  buf_q[BW'(wcnt_q)] <= spi_data_in;
                if (last) tied_q <= 1'b0;
                if (last && state_q == S_POLL) poll_q <= poll_q + PW'(1);
            end
            if (state_d == S_ERR && state_q != S_ERR) begin
                err_q  <= 1'b1;
                code_q <= (state_q == S_ID) ? CODE_ID : CODE_POLL;
            end
            // Byte handshake: pulse on ready, then see ready fall and rise before the next byte.
            if (tx_st) begin
                case (tx_ph_q)
                    PH_SEND: if (uart_ready_in && tx_idx_q != tx_len) begin
                        uart_en_q  <= 1'b1;
                        uart_dat_q <= tx_byte;
                        tx_idx_q   <= tx_idx_q + TXW'(1);
                        tx_ph_q    <= PH_WLO;
                    end
                    PH_WLO:  if (!uart_ready_in) tx_ph_q <= PH_WHI;
                    PH_WHI:  if (uart_ready_in)  tx_ph_q <= PH_SEND;
                    default: tx_ph_q <= PH_SEND;
                endcase
            end
        end
    end

    assign spi_en         = spi_en_q;
    assign spi_data_out   = spi_word;
    assign spi_data_words = words_q;
    assign tied_SS        = tied_q;
    assign busy           = (state_q != S_IDLE);
    assign error          = err_q;
    assign uart_en        = uart_en_q;
    assign uart_data_out  = uart_dat_q;

endmodule

// File: tb/tb_spi_sensor_seq.sv
// Bench for spi_sensor_seq: SPI sensor model and UART sink check against scoreboard queues.
module tb_spi_sensor_seq;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       uart_valid_in = 1'b0;
    logic [7:0] uart_data_in = 8'h00;
    logic       uart_ready_in = 1'b1;
    logic       uart_en;
    logic [7:0] uart_data_out;
    logic       spi_ready_in = 1'b1;
    logic       spi_valid_in = 1'b0;
    logic [7:0] spi_data_in = 8'h00;
    logic       spi_en;
    logic [7:0] spi_data_out;
    logic [5:0] spi_data_words;
    logic       tied_SS, busy, error;

    int total = 0, bad = 0;
    logic [7:0] exp_spi[$], exp_uart[$], stat_q[$];
    logic [7:0] id_val = 8'h58;
    logic [7:0] stat_default = 8'h00;
    int stat_reads = 0, wr_txns = 0, uart_cnt = 0, bw_done = 0;

`ifdef SEQ_FRAME_EN
    localparam int NB = 9;
`else
    localparam int NB = 7;
`endif

    always #5 clk = ~clk;

    spi_sensor_seq #(.POLL_LIMIT(4)) dut (
        .clk(clk), .n_rst(n_rst),
        .uart_valid_in(uart_valid_in), .uart_data_in(uart_data_in), .uart_ready_in(uart_ready_in),
        .uart_en(uart_en), .uart_data_out(uart_data_out),
        .spi_ready_in(spi_ready_in), .spi_valid_in(spi_valid_in), .spi_data_in(spi_data_in),
        .spi_en(spi_en), .spi_data_out(spi_data_out), .spi_data_words(spi_data_words),
        .tied_SS(tied_SS), .busy(busy), .error(error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SPI master plus sensor: compares each word at its start, answers by register address.
    initial begin : spi_master
        logic [7:0] addr;
        int nw;
        forever begin
            @(negedge clk);
            if (n_rst && spi_en) begin
                nw = int'(spi_data_words);
                chk("tied_SS_start", tied_SS, 1);
                spi_ready_in = 1'b0;
                addr = spi_data_out;
                if (!addr[7]) wr_txns++;
                if (addr == 8'hF3) stat_reads++;
                for (int w = 0; w < nw; w++) begin
                    if (!n_rst) break;
                    chk("spi_word_expected", exp_spi.size() != 0, 1);
                    if (exp_spi.size() != 0) chk("spi_word", spi_data_out, exp_spi.pop_front());
                    repeat (2) @(negedge clk);
                    if (!n_rst) break;
                    if (w == 0)                spi_data_in = 8'hFF;
                    else if (addr == 8'hD0)    spi_data_in = id_val;
                    else if (addr == 8'hF3) begin
                        if (stat_q.size() > 0) spi_data_in = stat_q.pop_front();
                        else                   spi_data_in = stat_default;
                    end
                    else                       spi_data_in = 8'(w);
                    spi_valid_in = 1'b1;
                    @(negedge clk);
                    spi_valid_in = 1'b0;
                    if (addr == 8'hF7) bw_done++;
                end
                if (n_rst) chk("tied_SS_drop", tied_SS, 0);
                spi_ready_in = 1'b1;
            end
        end
    end

    initial begin : uart_sink
        forever begin
            @(negedge clk);
            if (uart_en) begin
                uart_cnt++;
                chk("uart_byte_expected", exp_uart.size() != 0, 1);
                if (exp_uart.size() != 0) chk("uart_byte", uart_data_out, exp_uart.pop_front());
                uart_ready_in = 1'b0;
                repeat (3) @(negedge clk);
                uart_ready_in = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        uart_data_in  = b;
        uart_valid_in = 1'b1;
        @(negedge clk);
        uart_valid_in = 1'b0;
    endtask

    task automatic push_prog(input int polls, input bit burst);
        exp_spi.push_back(8'hD0); exp_spi.push_back(8'h00);
        exp_spi.push_back(8'h74); exp_spi.push_back(8'h27);
        exp_spi.push_back(8'h75); exp_spi.push_back(8'h00);
        for (int i = 0; i < polls; i++) begin
            exp_spi.push_back(8'hF3); exp_spi.push_back(8'h00);
        end
        if (burst) begin
            exp_spi.push_back(8'hF7);
            for (int i = 0; i < 6; i++) exp_spi.push_back(8'h00);
        end
    endtask

    task automatic push_payload(input logic [7:0] id);
        logic [7:0] x;
        x = id;
`ifdef SEQ_FRAME_EN
        exp_uart.push_back(8'hA5);
`endif
        exp_uart.push_back(id);
        for (int i = 1; i <= 6; i++) begin
            exp_uart.push_back(8'(i));
            x = x ^ 8'(i);
        end
`ifdef SEQ_FRAME_EN
        exp_uart.push_back(x);
`endif
    endtask

    task automatic push_err(input logic [7:0] code);
`ifdef SEQ_FRAME_EN
        exp_uart.push_back(8'hA5);
        exp_uart.push_back(code);
`endif
        exp_uart.push_back(code);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finished"}, n < 4000, 1);
    endtask

    task automatic run(input string tag);
        send(8'h6D);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_err_cleared"}, error, 0);
        wait_idle(tag);
    endtask

    task automatic wait_bw(input int target);
        int n;
        n = 0;
        while (bw_done < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("burst_progress", n < 2000, 1);
    endtask

    initial begin : main
        int u0, s0, w0, b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_uart_en", uart_en, 0);
        chk("rst_uart_data", uart_data_out, 0);
        chk("rst_spi_en", spi_en, 0);
        chk("rst_spi_data", spi_data_out, 0);
        chk("rst_spi_words", spi_data_words, 0);
        chk("rst_tied", tied_SS, 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // non-trigger byte in IDLE
        send(8'h41);
        repeat (10) @(negedge clk);
        chk("ign41_busy", busy, 0);
        chk("ign41_uart", uart_cnt, 0);

        // nominal run
        push_prog(1, 1); push_payload(8'h58);
        u0 = uart_cnt; s0 = stat_reads;
        run("nominal");
        chk("nominal_error", error, 0);
        chk("nominal_bytes", uart_cnt - u0, NB);
        chk("nominal_polls", stat_reads - s0, 1);
        chk("nominal_spi_q", exp_spi.size(), 0);
        chk("nominal_uart_q", exp_uart.size(), 0);

        // bad chip ID
        id_val = 8'h60;
        exp_spi.push_back(8'hD0); exp_spi.push_back(8'h00);
        push_err(8'hEE);
        w0 = wr_txns; u0 = uart_cnt;
        run("badid");
        chk("badid_error", error, 1);
        chk("badid_writes", wr_txns - w0, 0);
        chk("badid_bytes", uart_cnt - u0, exp_uart.size() == 0 ? u0 - u0 + (NB == 9 ? 3 : 1) : -1);
        repeat (20) @(negedge clk);
        chk("badid_err_sticky", error, 1);
        id_val = 8'h58;

        // status busy three times then ready
        stat_q.push_back(8'h08); stat_q.push_back(8'h08); stat_q.push_back(8'h08);
        push_prog(4, 1); push_payload(8'h58);
        s0 = stat_reads; u0 = uart_cnt;
        run("poll3");
        chk("poll3_reads", stat_reads - s0, 4);
        chk("poll3_bytes", uart_cnt - u0, NB);
        chk("poll3_error", error, 0);

        // status stuck busy: timeout at POLL_LIMIT=4
        stat_default = 8'h08;
        push_prog(4, 0); push_err(8'hEF);
        s0 = stat_reads;
        run("timeout");
        chk("timeout_reads", stat_reads - s0, 4);
        chk("timeout_error", error, 1);
        chk("timeout_uart_q", exp_uart.size(), 0);
        stat_default = 8'h00;

        // trigger during burst is dropped
        push_prog(1, 1); push_payload(8'h58);
        u0 = uart_cnt; b0 = bw_done; s0 = stat_reads;
        send(8'h6D);
        wait_bw(b0 + 3);
        send(8'h6D);
        wait_idle("retrig");
        repeat (40) @(negedge clk);
        chk("retrig_busy", busy, 0);
        chk("retrig_bytes", uart_cnt - u0, NB);
        chk("retrig_polls", stat_reads - s0, 1);
        chk("retrig_spi_q", exp_spi.size(), 0);

        // reset mid-burst
        push_prog(1, 1); push_payload(8'h58);
        b0 = bw_done;
        send(8'h6D);
        wait_bw(b0 + 4);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_spi_en", spi_en, 0);
        chk("arst_tied", tied_SS, 0);
        chk("arst_spi_data", spi_data_out, 0);
        chk("arst_spi_words", spi_data_words, 0);
        chk("arst_uart_en", uart_en, 0);
        chk("arst_error", error, 0);
        exp_spi.delete();
        exp_uart.delete();
        u0 = uart_cnt;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("arst_no_uart", uart_cnt - u0, 0);
        chk("arst_idle", busy, 0);

        // clean run after reset
        push_prog(1, 1); push_payload(8'h58);
        u0 = uart_cnt;
        run("post_rst");
        chk("post_rst_bytes", uart_cnt - u0, NB);
        chk("post_rst_error", error, 0);
        chk("post_rst_spi_q", exp_spi.size(), 0);
        chk("post_rst_uart_q", exp_uart.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
